// File: rtl/cw_pkg.sv
// cw_pkg: shared FSM states, LFSR polynomial and packet field layout for cw_chaffer
package cw_pkg;
  typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  function automatic int ctr_lsb(input int tagsize);
    return tagsize;
  endfunction
  function automatic int bit_pos(input int ctrsize, input int tagsize);
    return ctrsize + tagsize;
  endfunction
endpackage

// File: rtl/cw_lfsr.sv
// cw_lfsr: 32-bit right-shifting Galois LFSR exposing current and next tag/msb
module cw_lfsr
  import cw_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1,
  parameter int TAGSIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [TAGSIZE-1:0] cur_tag,
  output logic               cur_msb,
  output logic [TAGSIZE-1:0] nxt_tag,
  output logic               nxt_msb
);
  localparam logic [31:0] INIT = SEED == 32'h0 ? 32'h1 : SEED;
  logic [31:0] state, nxt;
  assign nxt = state[0] ? (state >> 1) ^ LFSR_POLY : state >> 1;
  assign cur_tag = state[TAGSIZE-1:0];
  assign cur_msb = state[31];
  assign nxt_tag = nxt[TAGSIZE-1:0];
  assign nxt_msb = nxt[31];
  always_ff @(posedge clk)
    if (rst) state <= INIT;
    else if (step) state <= nxt;
endmodule

// File: rtl/cw_chaffer.sv
// cw_chaffer: emits a wheat/chaff packet pair per message bit in pseudo-random order
module cw_chaffer
  import cw_pkg::*;
#(
  parameter int CWBITS = 32,
  parameter int CTRSIZE = 16,
  parameter int TAGSIZE = 16,
  parameter int CACHESIZE = 10,
  parameter logic [31:0] LFSR_SEED = 32'hACE10001
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              msg_valid,
  output logic                              msg_ready,
  input  logic [CWBITS-1:0]                 msg_data,
  input  logic                              tag_we,
  input  logic [$clog2(2*CACHESIZE)-1:0]    tag_waddr,
  input  logic [TAGSIZE-1:0]                tag_wdata,
  output logic                              pkt_valid,
  input  logic                              pkt_ready,
  output logic [CTRSIZE+TAGSIZE:0]          pkt_data,
  output logic                              pkt_last,
  output logic                              dbg_chaff
);
  localparam int AW = $clog2(2*CACHESIZE);
  localparam int PW = CACHESIZE > 1 ? $clog2(CACHESIZE) : 1;
  localparam int IW = CWBITS > 1 ? $clog2(CWBITS) : 1;
  localparam int BITP = bit_pos(CTRSIZE, TAGSIZE);
  localparam int CLSB = ctr_lsb(TAGSIZE);
  localparam logic [AW:0] NENT = (AW+1)'(2*CACHESIZE);
  state_t state, state_n;
  logic [CWBITS-1:0] sh, sh_nx;
  logic [IW-1:0] idx;
  logic [CTRSIZE-1:0] ctr, c_s;
  logic [PW-1:0] ptr, ptr_n, p_s;
  logic [TAGSIZE-1:0] cache [2*CACHESIZE];
  logic [TAGSIZE-1:0] cur_tag, nxt_tag, l_tag;
  logic cur_msb, nxt_msb, l_msb;
  logic take, fire, adv, second, last_bit, b_s, chaff_s;
  logic [AW-1:0] ridx;
  logic [CTRSIZE+TAGSIZE:0] pkt_n;
  assign take = msg_valid && msg_ready;
  assign fire = pkt_valid && pkt_ready;
  assign adv = state == EMIT_B;
  assign second = state == EMIT_A;
  assign last_bit = idx == IW'(CWBITS-1);
  assign sh_nx = sh >> 1;
  assign ptr_n = ptr == PW'(CACHESIZE-1) ? '0 : ptr + 1'b1;
  cw_lfsr #(.SEED(LFSR_SEED), .TAGSIZE(TAGSIZE)) u_lfsr (
    .clk(clk), .rst(rstn), .step(fire && adv),
    .cur_tag(cur_tag), .cur_msb(cur_msb), .nxt_tag(nxt_tag), .nxt_msb(nxt_msb)
  );
  // Operands of the packet registered at the next handshake: the first bit on
  // word accept, the pair's second half in EMIT_A, the following bit in EMIT_B.
  always_comb begin
    b_s = state == IDLE ? msg_data[0] : adv ? sh_nx[0] : sh[0];
    c_s = adv ? ctr + 1'b1 : ctr;
    p_s = adv ? ptr_n : ptr;
    l_tag = adv ? nxt_tag : cur_tag;
    l_msb = adv ? nxt_msb : cur_msb;
    chaff_s = second ? ~l_msb : l_msb;
    ridx = AW'({p_s, b_s});
    pkt_n = '0;
    pkt_n[BITP] = b_s ^ chaff_s;
    pkt_n[BITP-1:CLSB] = c_s;
    pkt_n[TAGSIZE-1:0] = chaff_s ? l_tag : cache[ridx];
  end
  always_comb begin
    state_n = state == IDLE ? (take ? EMIT_A : IDLE) :
              !fire ? state :
              second ? EMIT_B :
              last_bit ? IDLE : EMIT_A;
  end
  always_ff @(posedge clk)
    if (rstn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rstn) begin
      msg_ready <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_data <= '0;
      pkt_last <= 1'b0;
      dbg_chaff <= 1'b0;
      sh <= '0;
      idx <= '0;
      ctr <= '0;
      ptr <= '0;
    end else begin
      msg_ready <= state_n == IDLE;
      if (take) begin
        sh <= msg_data;
        idx <= '0;
      end
      if (fire && adv) begin
        sh <= sh_nx;
        idx <= idx + 1'b1;
        ctr <= ctr + 1'b1;
        ptr <= ptr_n;
      end
      if (take || fire) begin
        pkt_valid <= !(adv && last_bit);
        pkt_data <= pkt_n;
        pkt_last <= second && last_bit;
        dbg_chaff <= chaff_s;
      end
    end
  always_ff @(posedge clk)
    if (rstn) begin
      for (int i = 0; i < 2*CACHESIZE; i++) cache[i] <= '0;
    end else if (tag_we && {1'b0, tag_waddr} < NENT) begin
      cache[tag_waddr] <= tag_wdata;
    end
endmodule
